// File: rtl/decision_axil_slave.sv
// decision_axil_slave: AXI4-Lite control/status slave around a debounced
// hysteresis threshold decision with irq pulse and rising-edge event counter.
module decision_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int SENSOR_W           = 16,
  parameter int HOLD_COUNT         = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [SENSOR_W-1:0]             sensor_in,
  input  logic                            sensor_valid,
  output logic                            decision_out,
  output logic                            irq
);
  typedef enum logic {LOW, HIGH} state_e;
  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic aw_held_q, aw_held_d, w_held_q, w_held_d, bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, thresh_q, thresh_d, events_q, events_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic [2:0] ctrl_q, ctrl_d;
  logic [SENSOR_W-1:0] sample_q, sample_d, hi, lo;
  logic irq_q, irq_d, aw_hs, w_hs, ar_hs, commit, qual, toggle;
  logic [31:0] wmask, ctrl_rd, ctrl_w, status;
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [31:0] m);
    return (o & ~m) | (d & m);
  endfunction
  assign S_AXI_AWREADY = S_AXI_ARESETN && !aw_held_q && !bvalid_q;
  assign S_AXI_WREADY  = S_AXI_ARESETN && !w_held_q && !bvalid_q;
  assign S_AXI_ARREADY = S_AXI_ARESETN && !rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign decision_out  = state_q == HIGH;
  assign irq           = irq_q;
  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit = aw_held_q && w_held_q;
  assign hi     = thresh_q[SENSOR_W-1:0];
  assign lo     = thresh_q[16 +: SENSOR_W];
  assign qual   = state_q == LOW ? sensor_in > hi : sensor_in < lo;
  // clear bit always reads back as 0
  assign ctrl_rd = {29'b0, ctrl_q[2], 1'b0, ctrl_q[0]};
  assign status  = {16'(sample_q), cnt_q, 7'b0, decision_out};
  always_comb begin
    wmask = '0;
    for (int i = 0; i < 4; i++) wmask[8*i +: 8] = {8{wstrb_q[i]}};
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    toggle  = 1'b0;
    if (ctrl_q[1]) begin
      state_d = LOW;
      cnt_d   = '0;
    end else if (ctrl_q[0] && sensor_valid) begin
      if (!qual) cnt_d = '0;
      else if (cnt_q + 8'd1 == 8'(HOLD_COUNT)) begin
        toggle  = 1'b1;
        state_d = state_q == LOW ? HIGH : LOW;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 8'd1;
    end
  end
  always_comb begin
    aw_held_d = aw_hs ? 1'b1 : aw_held_q;
    awaddr_d  = aw_hs ? S_AXI_AWADDR[3:2] : awaddr_q;
    w_held_d  = w_hs ? 1'b1 : w_held_q;
    wdata_d   = w_hs ? S_AXI_WDATA : wdata_q;
    wstrb_d   = w_hs ? S_AXI_WSTRB : wstrb_q;
    bvalid_d  = commit ? 1'b1 : (bvalid_q && !S_AXI_BREADY);
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
    ctrl_w   = merge(ctrl_rd, wdata_q, wmask);
    ctrl_d   = commit && awaddr_q == 2'd0 ? ctrl_w[2:0] : ctrl_rd[2:0];
    thresh_d = commit && awaddr_q == 2'd1 ? merge(thresh_q, wdata_q, wmask) : thresh_q;
    // a software write to EVENTS overrides a coincident increment
    events_d = commit && awaddr_q == 2'd2 ? merge(events_q, wdata_q, wmask)
             : events_q + 32'(toggle && state_q == LOW);
    irq_d    = toggle && ctrl_q[2];
    sample_d = sensor_valid ? sensor_in : sample_q;
    rvalid_d = ar_hs ? 1'b1 : (rvalid_q && !S_AXI_RREADY);
    rdata_d  = !ar_hs ? rdata_q
             : S_AXI_ARADDR[3:2] == 2'd0 ? ctrl_rd
             : S_AXI_ARADDR[3:2] == 2'd1 ? thresh_q
             : S_AXI_ARADDR[3:2] == 2'd2 ? events_q : status;
  end
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q   <= LOW;
      cnt_q     <= '0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      thresh_q  <= '0;
      events_q  <= '0;
      sample_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      thresh_q  <= thresh_d;
      events_q  <= events_d;
      sample_q  <= sample_d;
      irq_q     <= irq_d;
    end
  end
endmodule
